instr_fetch_unit: RTL and testbench

//   Fetch stage upstream of the control unit. Holds the PC and fetches one instruction
//   at a time from instruction memory over a req/valid handshake. It latches the word

---
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and IMEM.
// The fetch stage drives req/addr; the memory drives rdy/valid/data.
interface instr_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            IMemReq;
  logic [XLEN-1:0] IMemAddr;
  logic            IMemRdy;
  logic            IMemValid;
  logic [XLEN-1:0] IMemData;

  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemRdy,
    input  IMemValid,
    input  IMemData
  );

  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemRdy,
    output IMemValid,
    output IMemData
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word at a time over the IMEM
// handshake, holds it for decode and steps the PC on Advance.
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  instr_fetch_unit_if.master imem,
  input  logic            Branch,
  input  logic            Zero,
  input  logic [XLEN-1:0] ImmExt,
  input  logic            Advance,
  output logic [XLEN-1:0] Instr,
  output logic [6:0]      OP,
  output logic [2:0]      Funct3,
  output logic [6:0]      Funct7,
  output logic [4:0]      Rs1,
  output logic [4:0]      Rs2,
  output logic [4:0]      Rd,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            InstrValid,
  output logic            FetchErr
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_e;

  localparam logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013);
  localparam logic [7:0]      WAIT_LIM = 8'(MAX_WAIT);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            taken;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] pc_br;
  logic [XLEN-1:0] pc_tgt;

  assign taken  = Branch & Zero;
  assign pc_seq = pc_q + XLEN'(4);
  assign pc_br  = pc_q + ImmExt;
  assign pc_tgt = taken ? pc_br : pc_seq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (imem.IMemRdy) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // data arriving on the timeout cycle still wins
        if (imem.IMemValid) begin
          instr_d = imem.IMemData;
          cnt_d   = '0;
          state_d = HOLD;
        end else if (cnt_q == WAIT_LIM) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (Advance) begin
          pc_d    = {pc_tgt[XLEN-1:2], 2'b00};
          err_d   = |pc_tgt[1:0];
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem.IMemReq  = (state_q == REQ);
  assign imem.IMemAddr = pc_q;

  assign Instr      = instr_q;
  assign OP         = instr_q[6:0];
  assign Funct3     = instr_q[14:12];
  assign Funct7     = instr_q[31:25];
  assign Rs1        = instr_q[19:15];
  assign Rs2        = instr_q[24:20];
  assign Rd         = instr_q[11:7];
  assign PC         = pc_q;
  assign PCPlus4    = pc_seq;
  assign InstrValid = (state_q == HOLD);
  assign FetchErr   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit against a transaction-level
// model of PC flow, memory contents and error pulses.
module tb_instr_fetch_unit;
  localparam int          XLEN   = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          MAXW   = 15;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] BEQ    = 32'h0020_8463;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic [31:0] ImmExt = '0;
  logic        Advance = 1'b0;
  logic [31:0] Instr;
  logic [6:0]  OP;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [4:0]  Rs1, Rs2, Rd;
  logic [31:0] PC, PCPlus4;
  logic        InstrValid, FetchErr;

  instr_fetch_unit_if #(.XLEN(XLEN)) imem ();

  instr_fetch_unit #(
    .XLEN(XLEN), .RESET_PC(RST_PC), .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .imem(imem),
    .Branch(Branch), .Zero(Zero), .ImmExt(ImmExt),
    .Advance(Advance), .Instr(Instr), .OP(OP),
    .Funct3(Funct3), .Funct7(Funct7), .Rs1(Rs1),
    .Rs2(Rs2), .Rd(Rd), .PC(PC), .PCPlus4(PCPlus4),
    .InstrValid(InstrValid), .FetchErr(FetchErr)
  );

  always #5 clk = ~clk;

  int          n_run = 0;
  int          n_fail = 0;
  logic [31:0] mem [256];
  logic [31:0] ep;
  logic [31:0] cur;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_dp();
    Advance = 1'($urandom_range(0, 1));
    Branch  = 1'($urandom_range(0, 1));
    Zero    = 1'($urandom_range(0, 1));
    ImmExt  = $urandom;
  endtask

  task automatic check_hold();
    chk("hold_iv", InstrValid, 1);
    chk("hold_instr", Instr, cur);
    chk("hold_op", OP, cur[6:0]);
    chk("hold_f3", Funct3, cur[14:12]);
    chk("hold_f7", Funct7, cur[31:25]);
    chk("hold_rs1", Rs1, cur[19:15]);
    chk("hold_rs2", Rs2, cur[24:20]);
    chk("hold_rd", Rd, cur[11:7]);
    chk("hold_pc", PC, ep);
    chk("hold_pc4", PCPlus4, ep + 32'd4);
    chk("hold_err", FetchErr, 0);
    chk("hold_req", imem.IMemReq, 0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem.IMemReq && n < 20) begin
      rand_dp();
      step();
      n++;
    end
    chk("req_seen", imem.IMemReq, 1);
    chk("req_addr", imem.IMemAddr, ep);
  endtask

  // lat: WAIT cycles before data; above MAXW forces a timeout then a retry
  task automatic fetch(input int lat);
    int  d;
    int  l = lat;
    bit  done = 0;
    while (!done) begin
      wait_req();
      d = $urandom_range(0, 2);
      repeat (d) begin
        imem.IMemRdy   = 1'b0;
        imem.IMemValid = 1'($urandom_range(0, 1));
        imem.IMemData  = $urandom;
        rand_dp();
        step();
      end
      imem.IMemValid = 1'b0;
      imem.IMemRdy   = 1'b1;
      rand_dp();
      step();
      imem.IMemRdy = 1'b0;
      chk("acc_req_drop", imem.IMemReq, 0);
      chk("acc_err", FetchErr, 0);
      if (l > MAXW) begin
        repeat (MAXW + 1) begin
          rand_dp();
          step();
        end
        chk("timeout_err", FetchErr, 1);
        chk("timeout_iv", InstrValid, 0);
        l = $urandom_range(0, 3);
      end else begin
        repeat (l) begin
          rand_dp();
          step();
        end
        cur            = mem[ep[9:2]];
        imem.IMemValid = 1'b1;
        imem.IMemData  = cur;
        Advance        = 1'b0;
        step();
        imem.IMemValid = 1'b0;
        imem.IMemData  = $urandom;
        check_hold();
        done = 1;
      end
    end
  endtask

  task automatic do_adv(input bit b, input bit z,
                        input logic [31:0] imm, input int hold);
    logic [31:0] tgt;
    repeat (hold) begin
      Advance = 1'b0;
      Branch  = 1'($urandom_range(0, 1));
      Zero    = 1'($urandom_range(0, 1));
      ImmExt  = $urandom;
      step();
      check_hold();
    end
    Branch  = b;
    Zero    = z;
    ImmExt  = imm;
    Advance = 1'b1;
    step();
    Advance = 1'b0;
    tgt = (b && z) ? ep + imm : ep + 32'd4;
    chk("adv_err", FetchErr, {31'd0, tgt[1:0] != 2'b00});
    chk("adv_iv", InstrValid, 0);
    chk("adv_instr_kept", Instr, cur);
    chk("adv_pc", PC, {tgt[31:2], 2'b00});
    ep = {tgt[31:2], 2'b00};
  endtask

  initial begin
    logic [31:0] imm;
    int          lat;
    int          sel;
    int          k;

    foreach (mem[i]) mem[i] = $urandom;
    mem[0]         = BEQ;
    imem.IMemRdy   = 1'b0;
    imem.IMemValid = 1'b0;
    imem.IMemData  = '0;
    ep             = RST_PC;
    cur            = NOP;

    step();
    step();
    chk("rst_iv", InstrValid, 0);
    chk("rst_instr", Instr, NOP);
    chk("rst_pc", PC, RST_PC);
    chk("rst_req", imem.IMemReq, 0);
    chk("rst_err", FetchErr, 0);
    rst_n = 1'b1;

    fetch(1);
    chk("beq_instr", Instr, BEQ);
    do_adv(1, 1, 32'd8, 0);
    fetch(0);
    do_adv(1, 0, 32'd8, 10);
    fetch(0);

    for (int r = 0; r < 3; r++) begin
      Advance      = 1'b1;
      Branch       = 1'b0;
      imem.IMemRdy = 1'b1;
      step();
      ep = ep + 32'd4;
      chk("thru_req", imem.IMemReq, 1);
      chk("thru_addr", imem.IMemAddr, ep);
      chk("thru_iv0", InstrValid, 0);
      step();
      chk("thru_wait", imem.IMemReq, 0);
      cur            = mem[ep[9:2]];
      imem.IMemValid = 1'b1;
      imem.IMemData  = cur;
      step();
      imem.IMemValid = 1'b0;
      chk("thru_iv1", InstrValid, 1);
      chk("thru_instr", Instr, cur);
    end
    Advance      = 1'b0;
    imem.IMemRdy = 1'b0;

    do_adv(0, 0, 32'd0, 0);
    fetch(MAXW + 1);
    do_adv(1, 1, 32'd6, 0);
    fetch(MAXW);
    do_adv(1, 1, 32'hFFFF_FFFC - ep, 1);
    fetch(0);
    do_adv(0, 1, 32'd0, 0);
    chk("wrap_pc", PC, 32'h0);

    for (int t = 0; t < 120; t++) begin
      sel = $urandom_range(0, 19);
      lat = (sel < 12) ? $urandom_range(0, 3) :
            (sel < 17) ? $urandom_range(4, MAXW) : MAXW + 1;
      fetch(lat);
      sel = $urandom_range(0, 9);
      k   = $urandom_range(0, 64) - 32;
      if (sel < 6)       imm = 32'(k * 4);
      else if (sel == 6) imm = 32'(k);
      else if (sel == 7) imm = 32'hFFFF_FFFC - ep;
      else               imm = $urandom;
      do_adv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             imm, $urandom_range(0, 3));
    end

    fetch(0);
    do_adv(0, 0, 32'd0, 0);
    wait_req();
    imem.IMemRdy = 1'b1;
    step();
    imem.IMemRdy = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", PC, RST_PC);
    chk("mid_rst_iv", InstrValid, 0);
    chk("mid_rst_instr", Instr, NOP);
    chk("mid_rst_req", imem.IMemReq, 0);
    step();
    rst_n          = 1'b1;
    imem.IMemValid = 1'b1;
    imem.IMemData  = $urandom;
    step();
    imem.IMemValid = 1'b0;
    chk("late_iv", InstrValid, 0);
    chk("late_instr", Instr, NOP);
    step();
    chk("late_iv2", InstrValid, 0);
    chk("late_instr2", Instr, NOP);
    chk("late_pc", PC, RST_PC);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
